// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants (RX, TX, APB registers)   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_e;

  localparam int   c_ovs_default = 16;
  localparam logic c_parity_odd  = 1'b0;
  localparam logic c_parity_even = 1'b1;

  // XOR over data plus parity bit must equal this for a clean frame.
  function automatic logic parity_target(input logic mode);
    return (mode == c_parity_even) ? 1'b0 : 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_sampler : 2-flop RXD synchroniser with mid-bit 3-way vote    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS   = c_ovs_default,
  parameter int CNT_W = $clog2(OVS)
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             baud_tick,
  input  logic             UART_RXD,
  input  logic [CNT_W-1:0] cnt,
  output logic             rxd_s,
  output logic             bit_sample
);

  localparam logic [CNT_W-1:0] c_samp0 = CNT_W'(OVS/2 - 1);
  localparam logic [CNT_W-1:0] c_samp1 = CNT_W'(OVS/2);

  logic rxd_meta_q, rxd_meta_d;
  logic rxd_sync_q, rxd_sync_d;
  logic samp0_q, samp0_d;
  logic samp1_q, samp1_d;

  always_comb begin
    rxd_meta_d = UART_RXD;
    rxd_sync_d = rxd_meta_q;
    samp0_d    = samp0_q;
    samp1_d    = samp1_q;
    if (baud_tick && (cnt == c_samp0)) samp0_d = rxd_sync_q;
    if (baud_tick && (cnt == c_samp1)) samp1_d = rxd_sync_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
    end
  end

  assign rxd_s = rxd_sync_q;
  // Third vote is the live synced value, so the result is usable on the OVS/2+1 tick itself.
  assign bit_sample = (samp0_q & samp1_q) | (samp0_q & rxd_sync_q) | (samp1_q & rxd_sync_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_deserializer : UART receive FSM, framing and RX FIFO handoff |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVS    = c_ovs_default,
  parameter int DATA_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              baud_tick,
  input  logic              UART_RXD,
  input  logic [3:0]        number_data_receive,
  input  logic              parity_en,
  input  logic              parity_bit_mode,
  input  logic              stop_bit_twice,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              rx_busy
);

  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] c_cnt_vote = CNT_W'(OVS/2 + 1);
  localparam logic [BIT_W-1:0] c_data_w   = BIT_W'(DATA_W);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [BIT_W-1:0]  nbits_q, nbits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d;
  logic              par_mode_q, par_mode_d;
  logic              stop2_q, stop2_d;
  logic              perr_acc_q, perr_acc_d;
  logic              ferr_acc_q, ferr_acc_d;

  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic              rxd_s;
  logic              bit_sample;
  logic              tick_vote;
  logic              tick_end;
  logic              frame_done;
  logic              done_ferr;
  logic [BIT_W-1:0]  nbits_cfg;
  logic [DATA_W-1:0] data_aligned;

  uart_rx_sampler #(
    .OVS   (OVS),
    .CNT_W (CNT_W)
  ) u_sampler (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .baud_tick  (baud_tick),
    .UART_RXD   (UART_RXD),
    .cnt        (cnt_q),
    .rxd_s      (rxd_s),
    .bit_sample (bit_sample)
  );

  assign tick_vote    = baud_tick && (cnt_q == c_cnt_vote);
  assign tick_end     = baud_tick && (cnt_q == c_cnt_last);
  // Bits shift in from the top, so an N-bit frame sits in the upper N bits.
  assign data_aligned = shreg_q >> (c_data_w - nbits_q);

  always_comb begin
    nbits_cfg = c_data_w;
    if ((int'(number_data_receive) >= 5) && (int'(number_data_receive) <= DATA_W)) begin
      nbits_cfg = BIT_W'(number_data_receive);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    frame_done = 1'b0;
    done_ferr  = ferr_acc_q;

    if (baud_tick) begin
      cnt_d = (cnt_q == c_cnt_last) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        nbits_d    = nbits_cfg;
        par_en_d   = parity_en;
        par_mode_d = parity_bit_mode;
        stop2_d    = stop_bit_twice;
        if (baud_tick && !rxd_s) begin
          state_d    = START;
          bit_idx_d  = '0;
          shreg_d    = '0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (tick_vote && bit_sample) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_vote) shreg_d = {bit_sample, shreg_q[DATA_W-1:1]};
        if (tick_end) begin
          if (bit_idx_q == nbits_q - 1'b1) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick_vote) perr_acc_d = (^{shreg_q, bit_sample}) != parity_target(par_mode_q);
        if (tick_end) state_d = STOP1;
      end
      STOP1: begin
        if (tick_vote) begin
          ferr_acc_d = ferr_acc_q | ~bit_sample;
          // Final stop bit: leave at mid-bit so a back-to-back start edge is not missed.
          if (!stop2_q) begin
            frame_done = 1'b1;
            done_ferr  = ferr_acc_q | ~bit_sample;
            state_d    = IDLE;
            cnt_d      = '0;
          end
        end else if (tick_end) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (tick_vote) begin
          ferr_acc_d = ferr_acc_q | ~bit_sample;
          frame_done = 1'b1;
          done_ferr  = ferr_acc_q | ~bit_sample;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rx_valid_d   = rx_valid_q && !rx_ready;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = data_aligned;
        parity_err_d = perr_acc_q;
        frame_err_d  = done_ferr;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      nbits_q      <= c_data_w;
      shreg_q      <= '0;
      par_en_q     <= 1'b0;
      par_mode_q   <= 1'b0;
      stop2_q      <= 1'b0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      nbits_q      <= nbits_d;
      shreg_q      <= shreg_d;
      par_en_q     <= par_en_d;
      par_mode_q   <= par_mode_d;
      stop2_q      <= stop2_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_deserializer : frame-level bench with reference model     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_rx_deserializer;

  localparam int OVS    = 16;
  localparam int DATA_W = 8;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              baud_tick = 1'b0;
  logic              UART_RXD = 1'b1;
  logic [3:0]        number_data_receive = 4'd8;
  logic              parity_en = 1'b1;
  logic              parity_bit_mode = 1'b1;
  logic              stop_bit_twice = 1'b0;
  logic              rx_ready = 1'b1;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun_err;
  logic              rx_busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   hs_count   = 0;
  int   ovr_cycles = 0;
  int   sent_count = 0;

  uart_rx_deserializer #(
    .OVS    (OVS),
    .DATA_W (DATA_W)
  ) dut (
    .PCLK                (PCLK),
    .PRESET              (PRESET),
    .baud_tick           (baud_tick),
    .UART_RXD            (UART_RXD),
    .number_data_receive (number_data_receive),
    .parity_en           (parity_en),
    .parity_bit_mode     (parity_bit_mode),
    .stop_bit_twice      (stop_bit_twice),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .parity_err          (parity_err),
    .frame_err           (frame_err),
    .overrun_err         (overrun_err),
    .rx_busy             (rx_busy)
  );

  initial forever #5 PCLK = ~PCLK;

  initial forever begin
    repeat (3) @(posedge PCLK);
    #1 baud_tick = 1'b1;
    @(posedge PCLK);
    #1 baud_tick = 1'b0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_bits(input logic [3:0] n);
    return (n >= 4'd5 && n <= 4'd8) ? int'(n) : 8;
  endfunction

  function automatic int count_ones(input logic [7:0] d, input int nb);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return ones;
  endfunction

  // Parity bit a well-behaved transmitter would send for this data.
  function automatic logic good_pbit(input logic [7:0] d, input int nb, input logic even);
    int ones = count_ones(d, nb);
    return even ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  function automatic exp_t model(input logic [7:0] d, input int nb, input logic pen,
                                 input logic even, input logic pbit, input logic s2en,
                                 input logic s1, input logic s2);
    exp_t e;
    int   ones = count_ones(d, nb);
    e.data = 8'(int'(d) % (1 << nb));
    e.perr = pen && (((ones + int'(pbit)) % 2) != (even ? 0 : 1));
    e.ferr = !s1 || (s2en && !s2);
    return e;
  endfunction

  task automatic wait_tick();
    do @(posedge PCLK); while (baud_tick !== 1'b1);
  endtask

  task automatic drive_bit(input logic b);
    UART_RXD = b;
    repeat (OVS) wait_tick();
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                            input logic s2, input bit expect_out, input int idle_bits);
    int nb = eff_bits(number_data_receive);
    if (expect_out) begin
      exp_q.push_back(model(d, nb, parity_en, parity_bit_mode, pbit, stop_bit_twice, s1, s2));
      sent_count++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (parity_en) drive_bit(pbit);
    drive_bit(s1);
    if (stop_bit_twice) drive_bit(s2);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
  endtask

  always @(negedge PCLK) begin : mon
    exp_t e;
    if (!PRESET && rx_valid && rx_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(rx_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rx_data", 32'(rx_data), 32'(e.data));
        check_eq("parity_err", 32'(parity_err), 32'(e.perr));
        check_eq("frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
    if (!PRESET && overrun_err) ovr_cycles++;
  end

  initial begin
    int   hs_before;
    logic [7:0] d;
    int   nb;
    logic pb;

    // Reset state
    repeat (4) @(negedge PCLK);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    @(posedge PCLK);
    #2 PRESET = 1'b0;
    wait_tick();
    #2;
    drive_bit(1'b1);

    // T1 / T2: even parity correct, then wrong, then odd mode
    send_frame(8'h6D, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    send_frame(8'h6D, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    parity_bit_mode = 1'b0;
    send_frame(8'h6D, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    parity_bit_mode = 1'b1;

    // T3: false start glitch
    hs_before = hs_count;
    UART_RXD = 1'b0;
    repeat (3) wait_tick();
    #2;
    check_eq("false_start_busy", 32'(rx_busy), 32'd1);
    repeat (3) wait_tick();
    #2;
    UART_RXD = 1'b1;
    repeat (OVS) wait_tick();
    #2;
    check_eq("false_start_idle", 32'(rx_busy), 32'd0);
    check_eq("false_start_no_frame", 32'(hs_count), 32'(hs_before));

    // T4: two stop bits, second one low
    stop_bit_twice = 1'b1;
    send_frame(8'h59, good_pbit(8'h59, 8, 1'b1), 1'b1, 1'b0, 1'b1, 1);
    stop_bit_twice = 1'b0;
    drive_bit(1'b1);

    // T5: overrun while FIFO stalls
    rx_ready = 1'b0;
    send_frame(8'h48, good_pbit(8'h48, 8, 1'b1), 1'b1, 1'b1, 1'b1, 0);
    send_frame(8'h45, good_pbit(8'h45, 8, 1'b1), 1'b1, 1'b1, 1'b0, 1);
    check_eq("ovr_valid_held", 32'(rx_valid), 32'd1);
    check_eq("ovr_data_kept", 32'(rx_data), 32'h48);
    check_eq("ovr_pulse_cycles", 32'(ovr_cycles), 32'd1);
    rx_ready = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    check_eq("consume_valid_low", 32'(rx_valid), 32'd0);

    // T6: 5-bit frames, reset mid-frame
    number_data_receive = 4'd5;
    parity_en = 1'b0;
    rx_ready = 1'b0;
    send_frame(8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    check_eq("n5_valid", 32'(rx_valid), 32'd1);
    check_eq("n5_data", 32'(rx_data), 32'(model(8'h15, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1).data));
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check_eq("mid_frame_busy", 32'(rx_busy), 32'd1);
    PRESET = 1'b1;
    UART_RXD = 1'b1;
    repeat (2) @(negedge PCLK);
    check_eq("mid_rst_valid", 32'(rx_valid), 32'd0);
    check_eq("mid_rst_data", 32'(rx_data), 32'd0);
    check_eq("mid_rst_flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    check_eq("mid_rst_busy", 32'(rx_busy), 32'd0);
    @(posedge PCLK);
    #2 PRESET = 1'b0;
    rx_ready = 1'b1;
    wait_tick();
    #2;
    drive_bit(1'b1);
    send_frame(8'h0A, 1'b0, 1'b1, 1'b1, 1'b1, 1);

    // Randomised frames against the reference model
    for (int k = 0; k < 25; k++) begin
      int r = int'($urandom_range(0, 9));
      number_data_receive = (r < 8) ? 4'(5 + (r % 4)) : 4'($urandom_range(0, 15));
      parity_en       = logic'($urandom_range(0, 1));
      parity_bit_mode = logic'($urandom_range(0, 1));
      stop_bit_twice  = logic'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      nb = eff_bits(number_data_receive);
      pb = good_pbit(d, nb, parity_bit_mode);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      send_frame(d, pb, logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 7) != 0),
                 1'b1, 1);
    end
    drive_bit(1'b1);

    check_eq("all_expected_seen", 32'(exp_q.size()), 32'd0);
    check_eq("frame_count", 32'(hs_count), 32'(sent_count));
    check_eq("overrun_total", 32'(ovr_cycles), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
